pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_stage_buf.sv | 138 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline register with optional skid entry.
// SKID=1 gives a two-entry buffer whose in_ready comes from a flop.
// SKID=0 gives a single-entry stage whose in_ready is combinational.
// Ports:
//   clk, rst         rising-edge clock, async active-high reset
//   flush            synchronous kill of all held entries
//   in_valid/ready   upstream handshake, in_data payload
//   out_valid/ready  downstream handshake, out_data payload
//   count            number of held entries (0..2)
module pipe_stage_buf #(
  parameter int unsigned      WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SKID      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  logic in_fire;
  logic out_fire;

  // A flush swallows any input handshake offered in the same cycle.
  assign in_fire  = in_valid & in_ready & ~flush;
  assign out_fire = out_valid & out_ready;

  if (SKID) begin : g_skid
    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             rdy_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= EMPTY;
        main_q  <= RESET_VAL;
        skid_q  <= RESET_VAL;
        rdy_q   <= 1'b1;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        // Registered ready: open whenever the skid slot will be free.
        rdy_q   <= (state_d != TWO);
      end
    end

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          unique case (1'b1)
            in_fire && out_fire: begin
              main_d = in_data;
            end
            in_fire && !out_fire: begin
              state_d = TWO;
              skid_d  = in_data;
            end
            !in_fire && out_fire: begin
              state_d = EMPTY;
            end
            default: ;
          endcase
        end
        TWO: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
      if (flush) begin
        state_d = EMPTY;
      end
    end

    assign in_ready  = rdy_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = out_valid ? main_q : RESET_VAL;
    assign count     = state_q;
  end else begin : g_single
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q  <= 1'b0;
        data_q <= RESET_VAL;
      end else begin
        vld_q  <= vld_d;
        data_q <= data_d;
      end
    end

    always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      if (flush) begin
        vld_d = 1'b0;
      end else if (in_fire) begin
        vld_d  = 1'b1;
        data_d = in_data;
      end else if (out_fire) begin
        vld_d = 1'b0;
      end
    end

    // Ready when empty, or when the held entry leaves this cycle.
    assign in_ready  = ~vld_q | out_ready;
    assign out_valid = vld_q;
    assign out_data  = vld_q ? data_q : RESET_VAL;
    assign count     = {1'b0, vld_q};
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: both SKID modes driven side by side and
// compared every cycle against a queue-based model.
module tb_pipe_stage_buf;

  localparam int unsigned      W  = 16;
  localparam logic [W-1:0]     RV = 16'h5A5A;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;

  logic         rdy0, ov0, rdy1, ov1;
  logic [W-1:0] od0, od1;
  logic [1:0]   cnt0, cnt1;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  always #5 clk = ~clk;

  pipe_stage_buf #(
    .WIDTH(W), .RESET_VAL(RV), .SKID(1'b0)
  ) u_s0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .out_valid(ov0),
    .out_ready(out_ready), .out_data(od0),
    .count(cnt0)
  );

  pipe_stage_buf #(
    .WIDTH(W), .RESET_VAL(RV), .SKID(1'b1)
  ) u_s1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .out_valid(ov1),
    .out_ready(out_ready), .out_data(od1),
    .count(cnt1)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h",
               tag, $time, got, exp);
    end
  endtask

  // Model view: a FIFO of accepted payloads; the head is on the output.
  task automatic check_all();
    int s0;
    int s1;
    s0 = q0.size();
    s1 = q1.size();
    chk("s0_count", 64'(cnt0), 64'(s0));
    chk("s0_valid", 64'(ov0), 64'(s0 > 0));
    chk("s0_data", 64'(od0), 64'(s0 > 0 ? q0[0] : RV));
    chk("s0_ready", 64'(rdy0), 64'(s0 == 0 || out_ready));
    chk("s1_count", 64'(cnt1), 64'(s1));
    chk("s1_valid", 64'(ov1), 64'(s1 > 0));
    chk("s1_data", 64'(od1), 64'(s1 > 0 ? q1[0] : RV));
    chk("s1_ready", 64'(rdy1), 64'(s1 < 2));
  endtask

  // Called just after a falling edge; returns after the next one.
  task automatic step(input logic iv, input logic [W-1:0] d,
                      input logic ordy, input logic fl);
    logic i0, o0, i1, o1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_all();
    i0 = iv && (q0.size() == 0 || ordy) && !fl;
    o0 = q0.size() > 0 && ordy;
    i1 = iv && q1.size() < 2 && !fl;
    o1 = q1.size() > 0 && ordy;
    @(posedge clk);
    if (fl) begin
      q0.delete();
      q1.delete();
    end else begin
      if (o0) void'(q0.pop_front());
      if (i0) q0.push_back(d);
      if (o1) void'(q1.pop_front());
      if (i1) q1.push_back(d);
    end
    @(negedge clk);
  endtask

  // Assert reset between edges and check it acts before any clock.
  task automatic do_reset();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #3;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Streaming 1..4 with the sink always ready.
    for (int i = 1; i <= 4; i++) step(1'b1, W'(i), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Backpressure then drain.
    step(1'b1, 16'h000A, 1'b0, 1'b0);
    step(1'b1, 16'h000B, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Flush from the full state with a competing input.
    step(1'b1, 16'h0001, 1'b0, 1'b0);
    step(1'b1, 16'h0002, 1'b0, 1'b0);
    step(1'b1, 16'h000C, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Single-entry pass-through replacement.
    step(1'b1, 16'h0005, 1'b0, 1'b0);
    step(1'b1, 16'h0006, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Async reset while the skid buffer is full.
    step(1'b1, 16'h0011, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 1'b0, 1'b0);
    do_reset();
    step(1'b0, '0, 1'b1, 1'b0);

    // Random traffic in both modes at once.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 3) != 0),
           W'($urandom),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 63) == 0));
    end
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
